// File: rtl/layer_scheduler.sv
// Object-table sequencer for the per-layer pixel drawer: walks valid sprites each frame,
// drives the drawer's position/index/run controls and a VRAM write strobe aligned to its pipeline.
module layer_scheduler #(
  parameter int unsigned NUM_OBJ      = 8,
  parameter int unsigned OBJ_A_WIDTH  = 3,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   frame_start,
  input  logic                   theme_in,
  input  logic                   obj_we,
  input  logic [OBJ_A_WIDTH-1:0] obj_waddr,
  input  logic                   obj_wvalid,
  input  logic [9:0]             obj_wx,
  input  logic [9:0]             obj_wy,
  input  logic [4:0]             obj_windex,
  input  logic                   i_layerend,
  output logic                   o_layer_rst,
  output logic                   o_is_cur_state,
  output logic [9:0]             o_screen_pos_x,
  output logic [9:0]             o_screen_pos_y,
  output logic [4:0]             o_sprite_index,
  output logic                   o_theme,
  output logic                   o_vram_we,
  output logic                   o_busy,
  output logic                   o_frame_done
);

  typedef enum logic [2:0] {StIdle, StScan, StLoad, StDraw, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [OBJ_A_WIDTH-1:0] idx_q, idx_d;
  logic                   first_q, first_d;
  logic [3:0]             drain_q, drain_d;
  logic                   load_en, theme_en, last_idx;

  logic [NUM_OBJ-1:0]     valid_q;
  logic [9:0]             x_mem   [NUM_OBJ];
  logic [9:0]             y_mem   [NUM_OBJ];
  logic [4:0]             idx_mem [NUM_OBJ];

  logic [9:0]             pos_x_q, pos_y_q;
  logic [4:0]             spr_q;
  logic                   theme_q;
  logic [1:0]             we_pipe_q;
  logic                   we_qual;

  assign last_idx = (idx_q == OBJ_A_WIDTH'(NUM_OBJ - 1));
  assign we_qual  = (state_q == StDraw) && !i_layerend;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    first_d  = first_q;
    drain_d  = drain_q;
    load_en  = 1'b0;
    theme_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d  = StScan;
          idx_d    = '0;
          theme_en = 1'b1;
        end
      end
      StScan: begin
        if (valid_q[idx_q]) begin
          state_d = StLoad;
          load_en = 1'b1;
        end else if (last_idx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StLoad: begin
        state_d = StDraw;
        first_d = 1'b1;
      end
      StDraw: begin
        // The drawer's end flag may still be left over from the previous object here.
        first_d = 1'b0;
        if (!first_q && i_layerend) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        if (drain_q == 4'(DRAIN_CYCLES - 1)) begin
          if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StScan;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      first_q   <= 1'b0;
      drain_q   <= '0;
      valid_q   <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      spr_q     <= '0;
      theme_q   <= 1'b0;
      we_pipe_q <= '0;
    end else if (ena) begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      first_q   <= first_d;
      drain_q   <= drain_d;
      we_pipe_q <= {we_pipe_q[0], we_qual};
      if (obj_we) valid_q[obj_waddr] <= obj_wvalid;
      if (theme_en) theme_q <= theme_in;
      if (load_en) begin
        pos_x_q <= x_mem[idx_q];
        pos_y_q <= y_mem[idx_q];
        spr_q   <= idx_mem[idx_q];
      end
    end
  end

  // Table payload needs no reset; only the valid bits qualify it.
  always_ff @(posedge CLK) begin
    if (ena && obj_we) begin
      x_mem[obj_waddr]   <= obj_wx;
      y_mem[obj_waddr]   <= obj_wy;
      idx_mem[obj_waddr] <= obj_windex;
    end
  end

  assign o_layer_rst    = (state_q == StLoad);
  assign o_is_cur_state = (state_q == StDraw) || (state_q == StDrain);
  assign o_screen_pos_x = pos_x_q;
  assign o_screen_pos_y = pos_y_q;
  assign o_sprite_index = spr_q;
  assign o_theme        = theme_q;
  assign o_vram_we      = we_pipe_q[1] && (state_q != StLoad);
  assign o_busy         = (state_q != StIdle);
  assign o_frame_done   = (state_q == StDone);

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler with a 4x2-pixel drawer model and cycle-level event counters.
module tb_layer_scheduler;

  logic       CLK = 1'b0;
  logic       rst, ena, frame_start, theme_in;
  logic       obj_we, obj_wvalid;
  logic [2:0] obj_waddr;
  logic [9:0] obj_wx, obj_wy;
  logic [4:0] obj_windex;
  logic       i_layerend;
  logic       o_layer_rst, o_is_cur_state, o_theme, o_vram_we, o_busy, o_frame_done;
  logic [9:0] o_screen_pos_x, o_screen_pos_y;
  logic [4:0] o_sprite_index;

  int vectors = 0;
  int errors  = 0;

  layer_scheduler #(.NUM_OBJ(8), .OBJ_A_WIDTH(3), .DRAIN_CYCLES(2)) dut (
    .CLK(CLK), .rst(rst), .ena(ena), .frame_start(frame_start), .theme_in(theme_in),
    .obj_we(obj_we), .obj_waddr(obj_waddr), .obj_wvalid(obj_wvalid), .obj_wx(obj_wx),
    .obj_wy(obj_wy), .obj_windex(obj_windex), .i_layerend(i_layerend),
    .o_layer_rst(o_layer_rst), .o_is_cur_state(o_is_cur_state),
    .o_screen_pos_x(o_screen_pos_x), .o_screen_pos_y(o_screen_pos_y),
    .o_sprite_index(o_sprite_index), .o_theme(o_theme), .o_vram_we(o_vram_we),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 CLK = ~CLK;

  // Drawer model: 4x2 sprite, layer end once all 8 pixels have been issued.
  int   dcnt = 8;
  logic manual_le = 1'b0;
  assign i_layerend = manual_le ? 1'b1 : (dcnt == 8);
  always @(posedge CLK) begin
    if (ena) begin
      if (o_layer_rst) dcnt <= 0;
      else if (o_is_cur_state && dcnt < 8) dcnt <= dcnt + 1;
    end
  end

  // Event counters, sampled on enabled cycles only.
  int cyc = 0, n_load = 0, n_we = 0, n_cur = 0, n_busy = 0, n_done = 0;
  int load_cyc = 0, first_we_cyc = 0, last_we_cyc = 0;
  logic we_seen = 1'b0;
  logic [9:0] ld_x [4];
  logic [9:0] ld_y [4];
  logic [4:0] ld_i [4];
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (ena) begin
      if (o_layer_rst) begin
        ld_x[n_load % 4] <= o_screen_pos_x;
        ld_y[n_load % 4] <= o_screen_pos_y;
        ld_i[n_load % 4] <= o_sprite_index;
        n_load   <= n_load + 1;
        load_cyc <= cyc;
        we_seen  <= 1'b0;
      end
      if (o_vram_we) begin
        n_we        <= n_we + 1;
        last_we_cyc <= cyc;
        if (!we_seen) begin
          first_we_cyc <= cyc;
          we_seen      <= 1'b1;
        end
      end
      if (o_is_cur_state) n_cur <= n_cur + 1;
      if (o_busy) n_busy <= n_busy + 1;
      if (o_frame_done) n_done <= n_done + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] snap();
    return {1'b0, o_layer_rst, o_is_cur_state, o_screen_pos_x, o_screen_pos_y, o_sprite_index,
            o_theme, o_vram_we, o_busy, o_frame_done};
  endfunction

  task automatic write_obj(input logic [2:0] a, input logic v, input logic [9:0] x,
                           input logic [9:0] y, input logic [4:0] si);
    obj_we = 1'b1; obj_waddr = a; obj_wvalid = v; obj_wx = x; obj_wy = y; obj_windex = si;
    @(negedge CLK);
    obj_we = 1'b0;
  endtask

  task automatic pulse_frame(input logic th);
    frame_start = 1'b1; theme_in = th;
    @(negedge CLK);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_frame_done && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check({tag, " done timeout"}, 32'(n < 500), 32'd1);
    @(negedge CLK);
  endtask

  task automatic wait_for_cur(input string tag, input logic need_we);
    int n = 0;
    while (!(o_is_cur_state && (!need_we || o_vram_we)) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check({tag, " wait timeout"}, 32'(n < 500), 32'd1);
  endtask

  int b_load, b_we, b_cur, b_busy, b_done;
  task automatic mark();
    b_load = n_load; b_we = n_we; b_cur = n_cur; b_busy = n_busy; b_done = n_done;
  endtask

  logic [31:0] frozen;

  initial begin
    rst = 1'b1; ena = 1'b1; frame_start = 1'b0; theme_in = 1'b0;
    obj_we = 1'b0; obj_waddr = '0; obj_wvalid = 1'b0; obj_wx = '0; obj_wy = '0; obj_windex = '0;
    repeat (3) @(negedge CLK);
    check("reset outputs", snap(), 32'd0);
    rst = 1'b0;

    // Two valid entries, plus a frame_start while busy that must be ignored.
    write_obj(3'd0, 1'b1, 10'd10, 10'd20, 5'd2);
    write_obj(3'd3, 1'b1, 10'd100, 10'd50, 5'd7);
    mark();
    pulse_frame(1'b1);
    repeat (5) @(negedge CLK);
    pulse_frame(1'b0);
    wait_done("two_obj");
    check("two_obj loads", 32'(n_load - b_load), 32'd2);
    check("two_obj pos0", {2'b0, ld_x[b_load % 4], ld_y[b_load % 4], ld_i[b_load % 4]},
          {2'b0, 10'd10, 10'd20, 5'd2});
    check("two_obj pos1", {2'b0, ld_x[(b_load + 1) % 4], ld_y[(b_load + 1) % 4],
          ld_i[(b_load + 1) % 4]}, {2'b0, 10'd100, 10'd50, 5'd7});
    check("two_obj busy cycles", 32'(n_busy - b_busy), 32'd33);
    check("two_obj strobes", 32'(n_we - b_we), 32'd16);
    check("two_obj run cycles", 32'(n_cur - b_cur), 32'd22);
    check("two_obj theme", 32'(o_theme), 32'd1);
    repeat (5) @(negedge CLK);
    check("two_obj single done", 32'(n_done - b_done), 32'd1);
    check("two_obj idle after", 32'(n_busy - b_busy), 32'd33);

    // Single entry: strobe count and alignment.
    write_obj(3'd0, 1'b0, 10'd0, 10'd0, 5'd0);
    write_obj(3'd3, 1'b0, 10'd0, 10'd0, 5'd0);
    write_obj(3'd5, 1'b1, 10'd300, 10'd200, 5'd17);
    mark();
    pulse_frame(1'b0);
    wait_done("one_obj");
    check("one_obj strobes", 32'(n_we - b_we), 32'd8);
    check("one_obj first strobe", 32'(first_we_cyc - load_cyc), 32'd3);
    check("one_obj last strobe", 32'(last_we_cyc - load_cyc), 32'd10);
    check("one_obj busy cycles", 32'(n_busy - b_busy), 32'd21);
    check("one_obj theme", 32'(o_theme), 32'd0);

    // Freeze mid-DRAW with ena low.
    mark();
    pulse_frame(1'b1);
    wait_for_cur("freeze", 1'b1);
    ena = 1'b0;
    frozen = snap();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("freeze hold", snap(), frozen);
    end
    ena = 1'b1;
    wait_done("freeze");
    check("freeze strobes", 32'(n_we - b_we), 32'd8);
    check("freeze busy cycles", 32'(n_busy - b_busy), 32'd21);
    check("freeze done", 32'(n_done - b_done), 32'd1);

    // Reset mid-DRAW.
    pulse_frame(1'b1);
    wait_for_cur("reset", 1'b0);
    rst = 1'b1;
    @(negedge CLK);
    check("reset mid pass", snap(), 32'd0);
    rst = 1'b0;
    @(negedge CLK);
    mark();
    pulse_frame(1'b0);
    wait_done("empty");
    check("empty loads", 32'(n_load - b_load), 32'd0);
    check("empty strobes", 32'(n_we - b_we), 32'd0);
    check("empty busy cycles", 32'(n_busy - b_busy), 32'd9);
    check("empty done", 32'(n_done - b_done), 32'd1);

    // Layer end held high: first DRAW cycle must ignore it.
    write_obj(3'd2, 1'b1, 10'd1, 10'd2, 5'd3);
    manual_le = 1'b1;
    mark();
    pulse_frame(1'b0);
    wait_done("stale_end");
    manual_le = 1'b0;
    check("stale_end run cycles", 32'(n_cur - b_cur), 32'd4);
    check("stale_end strobes", 32'(n_we - b_we), 32'd0);
    check("stale_end busy cycles", 32'(n_busy - b_busy), 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Upstream sequencer for the per-layer pixel drawer (drawLayer).
- Holds a small object table with one entry per sprite: screen position, sprite index and valid flag.
- On each frame-start pulse, walks the table. For every valid object it resets the drawer, drives that object's position and index, and enables drawing until the drawer reports layer end. It then drains the drawer's 2-stage address pipeline and produces an aligned VRAM write strobe.

Parameters:
- NUM_OBJ, 8, number of object table entries (power of 2, at most 32).
- OBJ_A_WIDTH, 3, object table address width, equal to log2(NUM_OBJ).
- DRAIN_CYCLES, 2, flush cycles after layer end; matches the drawer's address pipeline depth.

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ena  in  1  global clock enable. When low, all state, counters and the strobe pipeline hold; outputs hold their last values.
- frame_start  in  1  one-cycle pulse (vblank start) requesting a new pass.
- theme_in  in  1  theme select; sampled at pass start.
- obj_we  in  1  object table write strobe.
- obj_waddr  in  OBJ_A_WIDTH  object table write address.
- obj_wvalid  in  1  valid flag written to the entry.
- obj_wx  in  10  object left edge, in pixels.
- obj_wy  in  10  object top edge, in pixels.
- obj_windex  in  5  sprite index.
- i_layerend  in  1  layer end from the drawer.
- o_layer_rst  out  1  drawer layer reset.
- o_is_cur_state  out  1  drawer run enable.
- o_screen_pos_x  out  10  to drawer screen_pos_x.
- o_screen_pos_y  out  10  to drawer screen_pos_y.
- o_sprite_index  out  5  to drawer i_sprite_index.
- o_theme  out  1  to drawer theme_choose.
- o_vram_we  out  1  VRAM write enable, aligned with the drawer's address_screen.
- o_busy  out  1  high from pass start to pass end.
- o_frame_done  out  1  one-cycle pulse at pass end.

Behaviour:
- Reset: every output is 0; FSM is IDLE; object index is 0; table valid bits are cleared (other table fields are don't-care).
- All transitions below occur only on cycles where ena=1.
- Table write: registered, 1 cycle. It is allowed at any time. A write to the entry currently being drawn does not take effect until that entry is next loaded (position and index are latched in LOAD).
- FSM states: IDLE, SCAN, LOAD, DRAW, DRAIN, DONE.
  - IDLE: on frame_start, latch theme_in into o_theme, set object index to 0, set o_busy=1, go to SCAN. frame_start in any other state is ignored (no queuing).
  - SCAN: if the entry at the current index is valid, go to LOAD. Otherwise increment the index; if the index was NUM_OBJ-1, go to DONE instead. Costs 1 cycle per entry.
  - LOAD (1 cycle): o_layer_rst=1. Latch x, y and index into o_screen_pos_x, o_screen_pos_y and o_sprite_index. Go to DRAW.
  - DRAW: o_is_cur_state=1. Exit to DRAIN when i_layerend=1 is sampled, but i_layerend is ignored in the first DRAW cycle because the drawer's previous end flag can still be stale there.
  - DRAIN: o_is_cur_state=1 for DRAIN_CYCLES cycles so the drawer pipeline flushes. Then increment the index and go to SCAN, or go to DONE if the index was NUM_OBJ-1.
  - DONE (1 cycle): o_frame_done=1, o_busy=0 on the next cycle, return to IDLE.
- o_vram_we is a 2-stage shift of a qualifier: (state==DRAW && !i_layerend). It is therefore high exactly on the cycles when the drawer's address_screen carries the address of an in-range pixel. It is forced to 0 during LOAD.
- Position and index outputs stay stable from LOAD through the end of DRAIN.
- Index counter: OBJ_A_WIDTH bits. Pass end is detected before wrap, so the counter never wraps mid-pass.
- Reset mid-pass: immediately go to IDLE with all outputs 0; no o_frame_done pulse. Table valid bits are cleared.

Test Plan:
- Reset, write entries 0 and 3 valid (entry 0: x=10, y=20, index=2; entry 3: x=100, y=50, index=7), pulse frame_start.
  -> Exactly 2 LOAD pulses, with pos/index (10,20,2) then (100,50,7).
  -> o_frame_done fires once; o_busy is high throughout the pass.
- Drawer model with PIX_WIDTH=4, PIX_HEIGHT=2, one valid entry.
  -> o_vram_we high for exactly 8 cycles.
  -> First strobe 2 cycles after the first DRAW cycle; none after DRAIN ends.
- Empty table, pulse frame_start.
  -> NUM_OBJ SCAN cycles, then o_frame_done; o_layer_rst and o_vram_we stay 0.
- Second frame_start while busy.
  -> Ignored; exactly one o_frame_done. A frame_start after DONE starts a new pass.
- Hold ena=0 for 5 cycles mid-DRAW.
  -> State, outputs and o_vram_we pipeline frozen; resuming gives an identical strobe count.
- Assert rst mid-DRAW.
  -> Next cycle all outputs are 0 and state is IDLE.
  -> A following frame_start with no table writes completes with zero LOAD pulses.
